alu_seq_unit: RTL and testbench

Parametrised, handshaked ALU execution unit for the LEGv8 datapath. Decodes the 2-bit ALUOp from main control plus the 11-bit R-type opcode field into an internal operation code. Executes ADD/SUB/AND/ORR/pass-B in one cycle and MUL iteratively over multiple cycles. Sits between register read and writeback, with valid/ready on both sides so a multi-cycle multiply can stall the pipeline.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_op_decode.sv | 31 +++
 rtl/alu_seq_unit.sv | 144 ++++++++++++++
 tb/tb_alu_seq_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, LEGv8 R-type opcode constants and FSM state type for the ALU unit.
// Multiply support is controlled by the ALU_SEQ_MUL_EN macro.
package alu_pkg;

  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_ORR     = 4'b0001;
  localparam logic [3:0] OP_ADD     = 4'b0010;
  localparam logic [3:0] OP_SUB     = 4'b0110;
  localparam logic [3:0] OP_PASSB   = 4'b0111;
  localparam logic [3:0] OP_MUL     = 4'b1000;
  localparam logic [3:0] OP_ILLEGAL = 4'b1111;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;
  localparam logic [10:0] OPC_MUL = 11'b10011011000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp + R-type opcode to internal op code decode.
// MUL decodes only when ALU_SEQ_MUL_EN is defined; otherwise it is ILLEGAL.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0]  alu_op,
  input  logic [10:0] opcode,
  output logic [3:0]  op
);

  always_comb begin
    op = OP_ILLEGAL;
    if (alu_op[0]) begin
      op = OP_PASSB;
    end else if (!alu_op[1]) begin
      op = OP_ADD;
    end else begin
      case (opcode)
        OPC_ADD: op = OP_ADD;
        OPC_SUB: op = OP_SUB;
        OPC_AND: op = OP_AND;
        OPC_ORR: op = OP_ORR;
`ifdef ALU_SEQ_MUL_EN
        OPC_MUL: op = OP_MUL;
`endif
        default: op = OP_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked LEGv8 ALU: single-cycle ADD/SUB/AND/ORR/PASSB, iterative shift-add MUL.
// MUL datapath and FSM exist only when ALU_SEQ_MUL_EN is defined.
//
//   state   | meaning
//   ST_IDLE | accepting requests, single-cycle ops load the output register
//   ST_MUL  | one multiplier slice retired per cycle, in_ready held low
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [10:0]      opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  if (WIDTH < 8) begin : g_bad_width
    $error("alu_seq_unit: WIDTH must be at least 8");
  end
  if ((MUL_BITS < 1) || (WIDTH % MUL_BITS != 0)) begin : g_bad_mul_bits
    $error("alu_seq_unit: MUL_BITS must divide WIDTH");
  end

  logic [3:0]       op;
  logic [WIDTH-1:0] res_1c;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             load_ill;

  alu_op_decode u_dec (
    .alu_op (alu_op),
    .opcode (opcode),
    .op     (op)
  );

  always_comb begin
    res_1c = '0;
    case (op)
      OP_ADD:   res_1c = a + b;
      OP_SUB:   res_1c = a + ~b + WIDTH'(1);
      OP_AND:   res_1c = a & b;
      OP_ORR:   res_1c = a | b;
      OP_PASSB: res_1c = b;
      default:  res_1c = '0;
    endcase
  end

  assign accept = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
  localparam int ITERS = WIDTH / MUL_BITS;
  localparam int CNT_W = $clog2(ITERS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, mcand, mplier, partial, acc_nx;
  logic             mul_start, mul_done;

  assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
  assign mul_start = accept && (op == OP_MUL);
  assign mul_done  = (state == ST_MUL) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (mul_start) state_nx = ST_MUL;
      ST_MUL:  if (mul_done)  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Shift-add over one multiplier slice; avoids a full WIDTH x WIDTH multiplier.
  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (mplier[i]) partial = partial + (mcand << i);
    end
    acc_nx = acc + partial;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (mul_start) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (state == ST_MUL) begin
      cnt    <= mul_done ? '0 : cnt + CNT_W'(1);
      acc    <= acc_nx;
      mcand  <= mcand << MUL_BITS;
      mplier <= mplier >> MUL_BITS;
    end
  end

  assign load     = (accept && (op != OP_MUL)) || mul_done;
  assign load_val = mul_done ? acc_nx : res_1c;
  assign load_ill = !mul_done && (op == OP_ILLEGAL);
`else
  assign in_ready = !out_valid || out_ready;
  assign load     = accept;
  assign load_val = res_1c;
  assign load_ill = (op == OP_ILLEGAL);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      illegal   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      result    <= load_val;
      zero      <= (load_val == '0);
      illegal   <= load_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: directed vectors, expected results queued at issue
// and popped by an independent monitor whenever a result is handed off.
module tb_alu_seq_unit;
  import alu_pkg::*;

  localparam int W = 64;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         il;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid, in_ready, out_valid, out_ready, zero, illegal;
  logic [1:0]   alu_op;
  logic [10:0]  opcode;
  logic [W-1:0] a, b, result;

  logic         in_valid4, in_ready4, out_valid4, out_ready4, zero4, illegal4;
  logic [1:0]   alu_op4;
  logic [10:0]  opcode4;
  logic [W-1:0] a4, b4, result4;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(W), .MUL_BITS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .opcode(opcode), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal)
  );

  alu_seq_unit #(.WIDTH(W), .MUL_BITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .alu_op(alu_op4), .opcode(opcode4), .a(a4), .b(b4),
    .out_valid(out_valid4), .out_ready(out_ready4), .result(result4),
    .zero(zero4), .illegal(illegal4)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic il);
    exp_t e;
    e.r  = r;
    e.z  = (r == '0);
    e.il = il;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%h required=no_result", result);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", result, e.r);
        chk("sb_zero", W'(zero), W'(e.z));
        chk("sb_illegal", W'(illegal), W'(e.il));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [10:0] opc,
                       input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input exp_t e, input bit push);
    int n = 0;
    alu_op   = op;
    opcode   = opc;
    a        = aa;
    b        = bb;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout actual=in_ready_low required=in_ready_high");
    end else if (push) begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] mul_prod;
    exp_t         mul_exp;
    time          t0;
    int           n;

    ones     = '1;
    mul_prod = ones - W'(2);
    mul_exp  = MUL_ON ? mk(mul_prod, 1'b0) : mk('0, 1'b1);

    in_valid = 0; alu_op = 0; opcode = 0; a = 0; b = 0; out_ready = 1;
    in_valid4 = 0; alu_op4 = 2'b10; opcode4 = OPC_MUL; a4 = ones; b4 = W'(3); out_ready4 = 1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_result", result, '0);
    chk("rst_zero", W'(zero), W'(1));
    chk("rst_illegal", W'(illegal), '0);
    chk("rst_in_ready", W'(in_ready), W'(1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    t0 = $time;
    issue(2'b10, OPC_ADD, W'(5), W'(7), mk(W'(12), 1'b0), 1'b1);
    issue(2'b10, OPC_SUB, W'(3), W'(3), mk('0, 1'b0), 1'b1);
    issue(2'b10, OPC_SUB, W'(0), W'(1), mk(ones, 1'b0), 1'b1);
    chk("throughput_ns", W'($time - t0), W'(30));
    issue(2'b01, OPC_ADD, W'(9), W'(0), mk('0, 1'b0), 1'b1);
    issue(2'b00, OPC_SUB, W'(4), W'(4), mk(W'(8), 1'b0), 1'b1);
    issue(2'b10, OPC_AND, W'(16'hF0F0), W'(16'hFF00), mk(W'(16'hF000), 1'b0), 1'b1);
    issue(2'b10, OPC_ORR, W'(16'hF0F0), W'(16'h0F0F), mk(W'(16'hFFFF), 1'b0), 1'b1);
    issue(2'b10, OPC_ADD, ones, W'(1), mk('0, 1'b0), 1'b1);
    issue(2'b11, OPC_MUL, W'(7), W'(16'h1234), mk(W'(16'h1234), 1'b0), 1'b1);

    issue(2'b10, OPC_MUL, ones, W'(3), mul_exp, 1'b1);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("mul1_latency", W'(n), MUL_ON ? W'(64) : W'(0));
    chk("mul1_out_valid", W'(out_valid), W'(1));

    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(2'b10, 11'b11111111111, W'(3), W'(4), mk('0, 1'b1), 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_flags", W'({out_valid, in_ready, illegal, zero}), W'(4'b1011));
      chk("hold_result", result, '0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;

    @(posedge clk);
    #1;
    issue(2'b10, OPC_MUL, W'(5), W'(6), mk('0, 1'b1), !MUL_ON);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", W'(out_valid), '0);
    chk("midrst_in_ready", W'(in_ready), W'(1));
    chk("midrst_result", result, '0);
    chk("midrst_zero", W'(zero), W'(1));
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(2'b10, OPC_ADD, W'(1), W'(1), mk(W'(2), 1'b0), 1'b1);

    in_valid4 = 1'b1;
    @(negedge clk);
    chk("mul4_accept_ready", W'(in_ready4), W'(1));
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!in_ready4 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("mul4_latency", W'(n), MUL_ON ? W'(16) : W'(0));
    chk("mul4_out_valid", W'(out_valid4), W'(1));
    chk("mul4_result", result4, MUL_ON ? mul_prod : '0);
    chk("mul4_illegal", W'(illegal4), MUL_ON ? W'(0) : W'(1));

    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    chk("sb_drain", W'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
